imem_responder: RTL
===================

// Module: imem_responder
// PURPOSE
//  Responder end of the fetch-side instruction read interface: accepts one
//  word-read request at a time from the fetch stage, issues it to a fixed-
//  latency synchronous instruction memory (i_cache ROM), returns the word with
//  a one-cycle rsp_valid pulse. Supports request abort on PC redirect (flush).
// PARAMETERS
//  AW       32  address width (byte address)
//  DW       32  instruction word width
//  MEM_LAT  1   cycles from mem_rd cycle to mem_data_i valid (>=1)
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  cpu_req     in   1   read request, qualified by cpu_ready
//  cpu_addr    in   AW  byte address of requested word
//  cpu_ready   out  1   1 only in IDLE and rst=0; accept = cpu_req & cpu_ready
//  flush       in   1   abort outstanding request (branch/jump redirect)
//  rsp_valid   out  1   one-cycle pulse, response data/err valid
//  rsp_data    out  DW  instruction word
//  rsp_err     out  1   misaligned-address error with this response
//  mem_rd      out  1   memory read strobe, exactly one cycle per access
//  mem_addr    out  AW  word address to memory = req_addr[AW-1:2]
//  mem_data_i  in   DW  memory read data, valid MEM_LAT cycles after mem_rd
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, cnt=0, rsp_valid=0, rsp_data=0,
//    rsp_err=0, mem_rd=0, mem_addr=0, cpu_ready=0 while rst high. Reset
//    mid-access abandons it; no response is ever produced for it.
//  - States IDLE, ISSUE, WAIT, RESP, DRAIN. All outputs registered except cpu_ready.
//  - IDLE: flush=1 -> stay, request not accepted (flush wins over cpu_req).
//    accept & cpu_addr[1:0]!=0 -> RESP with rsp_err=1, rsp_data=32'h00000013
//    (NOP), no memory access. accept aligned -> latch addr, ISSUE.
//  - ISSUE: mem_rd=1, mem_addr=latched addr>>2; cnt<=MEM_LAT; -> WAIT,
//    or -> DRAIN if flush=1 (access already launched, cannot be cancelled).
//  - WAIT: cnt decrements each cycle; at cnt==1 sample mem_data_i -> RESP.
//    flush=1 -> DRAIN, cnt continues.
//  - DRAIN: same count, at cnt==1 -> IDLE, data discarded, no rsp_valid;
//    flush ignored. Memory data never returned after an abort.
//  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. Flush in RESP has no
//    effect: response is delivered, requester discards it. rsp_data/rsp_err
//    hold last value after pulse until next response.
//  - Latency: accept at cycle 0 -> mem_rd cycle 1 -> rsp_valid cycle MEM_LAT+2.
//    Misaligned: rsp_valid cycle 1. Next accept earliest cycle after RESP.
//  - No backpressure on response; exactly one response per non-aborted accept.
//  - Address: mem_addr drops bits [1:0]; upper bits pass unchanged, no wrap logic.
// CONFIGURATION
//  IMEM_HIT_BUF_EN defined: one-entry last-word buffer {buf_vld, buf_addr,
//   buf_data}, written on every completed (non-aborted) memory read. Aligned
//   accept with buf_vld & cpu_addr[AW-1:2]==buf_addr -> RESP next cycle with
//   buf_data, no mem_rd (latency 1). Cleared by rst only; flush leaves it valid.
//  Not defined: no buffer, every aligned request accesses memory.
// TESTING
//  1 rst 2 cycles, release -> all outputs 0, cpu_ready=1 cycle after release.
//  2 MEM_LAT=1, req addr 0x10, mem returns 0x00500093 -> mem_rd=1 cycle 1,
//    mem_addr=0x4, rsp_valid cycle 3, rsp_data=0x00500093, rsp_err=0.
//  3 req addr 0x22 -> no mem_rd, rsp_valid cycle 1, rsp_err=1, rsp_data=0x13.
//  4 req 0x40, flush in ISSUE cycle -> mem_rd seen once, no rsp_valid,
//    cpu_ready back after MEM_LAT drain; next req 0x44 returns correct word.
//  5 flush and cpu_req same IDLE cycle -> not accepted; rst mid-WAIT -> no rsp.
//  6 IMEM_HIT_BUF_EN: req 0x10 twice -> 2nd: no mem_rd, rsp_valid cycle 1,
//    same data; req 0x14 -> memory access. Without macro, both reads hit memory.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch/memory bus bundle for imem_responder.
// slave = responder view, master = fetch stage plus instruction memory view.
interface imem_responder_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ready;
    logic          flush;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_i;

    modport slave (
        input  cpu_req,
        input  cpu_addr,
        input  flush,
        input  mem_data_i,
        output cpu_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err,
        output mem_rd,
        output mem_addr
    );

    modport master (
        output cpu_req,
        output cpu_addr,
        output flush,
        output mem_data_i,
        input  cpu_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err,
        input  mem_rd,
        input  mem_addr
    );
endinterface

// File: rtl/imem_responder.sv
// Single-outstanding instruction read responder in front of a fixed-latency ROM.
// Define IMEM_HIT_BUF_EN to add a one-entry last-word buffer that skips memory on a repeat fetch.
module imem_responder #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    imem_responder_if.slave bus
);
    localparam int unsigned   CntW = $clog2(MEM_LAT + 1);
    localparam logic [DW-1:0] Nop  = DW'(32'h0000_0013);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            mem_rd_q, mem_rd_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;

    logic            accept;
    logic            misaligned;
    logic            wait_done;
    logic            buf_hit;
    logic [DW-1:0]   buf_rdata;

    assign bus.cpu_ready = (state_q == StIdle) && !rst;
    assign accept        = bus.cpu_req && bus.cpu_ready && !bus.flush;
    assign misaligned    = |bus.cpu_addr[1:0];
    assign wait_done     = (state_q == StWait) && (cnt_q == CntW'(1));

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;

`ifdef IMEM_HIT_BUF_EN
    logic          buf_vld_q;
    logic [AW-3:0] buf_addr_q;
    logic [DW-1:0] buf_data_q;

    assign buf_hit   = buf_vld_q && (bus.cpu_addr[AW-1:2] == buf_addr_q);
    assign buf_rdata = buf_data_q;

    // Only a read that actually returned data is cached; flush does not invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else if (wait_done && !bus.flush) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= mem_addr_q[AW-3:0];
            buf_data_q <= bus.mem_data_i;
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = Nop;
                    end else if (buf_hit) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = buf_rdata;
                    end else begin
                        state_d    = StIssue;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = AW'(bus.cpu_addr[AW-1:2]);
                    end
                end
            end
            StIssue: begin
                cnt_d   = CntW'(MEM_LAT);
                state_d = bus.flush ? StDrain : StWait;
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                // A flush on the final wait cycle leaves nothing to drain.
                if (bus.flush) begin
                    state_d = (cnt_q == CntW'(1)) ? StIdle : StDrain;
                end else if (cnt_q == CntW'(1)) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = bus.mem_data_i;
                end
            end
            StDrain: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
        end
    end
endmodule
